// File: rtl/spi_arb_pkg.sv
// Shared types and sizing helpers for the SPI master arbiter.
package spi_arb_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      ISSUE,
      WAIT_BUSY,
      WAIT_DONE,
      NEXT,
      HOLD
   } arb_state_t;

   localparam int DEF_NUM_REQ     = 4;
   localparam int DEF_DATA_WIDTH  = 8;
   localparam int DEF_CS_SETUP    = 4;
   localparam int DEF_CS_HOLD     = 4;
   localparam int DEF_GAP_TIMEOUT = 255;

   // Width of a counter that runs 0 .. max_count-1.
   function automatic int cnt_width(input int max_count);
      return (max_count < 2) ? 1 : $clog2(max_count);
   endfunction

endpackage

// File: rtl/spi_rr_pick.sv
// Combinational round-robin picker: first request strictly after i_ptr, wrapping.
module spi_rr_pick #(
   parameter  int NUM_REQ = 4,
   localparam int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IDX_W-1:0]   i_ptr,
   output logic [IDX_W-1:0]   o_grant,
   output logic               o_any
);

   int idx;

   always_comb begin
      // NOTE: every output gets a default before the loop so no path holds a stale value (no latch).
      o_grant = '0;
      o_any   = 1'b0;
      idx     = 0;
      // Walk from farthest to nearest so the nearest hit is the last write.
      for (int k = NUM_REQ; k >= 1; k--) begin
         idx = int'(i_ptr) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (i_req[idx]) begin
            o_grant = IDX_W'(idx);
            o_any   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/spi_master_arbiter.sv
// Shares one SPI byte engine among NUM_REQ clients: round-robin per burst,
// per-client chip select with setup/hold sequencing and inter-byte gap timeout.
module spi_master_arbiter
   import spi_arb_pkg::*;
#(
   parameter  int NUM_REQ     = DEF_NUM_REQ,
   parameter  int DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter  int CS_SETUP    = DEF_CS_SETUP,
   parameter  int CS_HOLD     = DEF_CS_HOLD,
   parameter  int GAP_TIMEOUT = DEF_GAP_TIMEOUT,
   localparam int IDX_W       = $clog2(NUM_REQ)
) (
   input  logic                          sysclk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ-1:0]            req_last,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic [NUM_REQ-1:0]            rsp_valid,
   output logic [DATA_WIDTH-1:0]         rsp_data,
   output logic [NUM_REQ-1:0]            cs_n,
   output logic                          spi_req,
   output logic [DATA_WIDTH-1:0]         spi_tx_data,
   input  logic                          spi_busy,
   input  logic                          spi_rx_valid,
   input  logic [DATA_WIDTH-1:0]         spi_rx_data,
   output logic [IDX_W-1:0]              grant_idx,
   output logic                          arb_busy,
   output logic                          timeout_err
);

   localparam int CNT_MAX0 = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
   localparam int CNT_MAX  = (CNT_MAX0 > GAP_TIMEOUT) ? CNT_MAX0 : GAP_TIMEOUT;
   localparam int CNT_W    = cnt_width(CNT_MAX);

   arb_state_t              r_state;
   logic [IDX_W-1:0]        r_ptr;
   logic [IDX_W-1:0]        r_grant;
   logic [NUM_REQ-1:0]      r_cs_n;
   logic [NUM_REQ-1:0]      r_req_ready;
   logic [NUM_REQ-1:0]      r_rsp_valid;
   logic [DATA_WIDTH-1:0]   r_rsp_data;
   logic                    r_spi_req;
   logic [DATA_WIDTH-1:0]   r_tx_data;
   logic                    r_last;
   logic [CNT_W-1:0]        r_cnt;
   logic                    r_timeout;
   logic                    r_arb_busy;

   logic [IDX_W-1:0]        w_pick;
   logic                    w_any;
   logic [NUM_REQ-1:0]      w_grant_1h;
   logic                    w_grant_valid;
   logic                    w_grant_last;
   logic [DATA_WIDTH-1:0]   w_grant_data;

   spi_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
      .i_req   (req_valid),
      .i_ptr   (r_ptr),
      .o_grant (w_pick),
      .o_any   (w_any)
   );

   assign w_grant_1h    = NUM_REQ'(1) << r_grant;
   assign w_grant_valid = req_valid[r_grant];
   assign w_grant_last  = req_last[r_grant];
   assign w_grant_data  = req_data[r_grant*DATA_WIDTH +: DATA_WIDTH];

   // NOTE: non-blocking assignments so every register sees pre-edge values of the others.
   always_ff @(posedge sysclk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_ptr       <= IDX_W'(NUM_REQ - 1);
         r_grant     <= '0;
         r_cs_n      <= '1;
         r_req_ready <= '0;
         r_rsp_valid <= '0;
         r_rsp_data  <= '0;
         r_spi_req   <= 1'b0;
         r_tx_data   <= '0;
         r_last      <= 1'b0;
         r_cnt       <= '0;
         r_timeout   <= 1'b0;
         r_arb_busy  <= 1'b0;
      end else begin
         r_req_ready <= '0;
         r_rsp_valid <= '0;
         r_spi_req   <= 1'b0;
         r_timeout   <= 1'b0;
         case (r_state)
            IDLE: if (w_any) begin
               r_grant    <= w_pick;
               r_cs_n     <= ~(NUM_REQ'(1) << w_pick);
               r_cnt      <= '0;
               r_arb_busy <= 1'b1;
               r_state    <= SETUP;
            end
            SETUP: if (r_cnt == CNT_W'(CS_SETUP - 1)) begin
               r_cnt <= '0;
               if (w_grant_valid) begin
                  r_req_ready <= w_grant_1h;
                  r_spi_req   <= 1'b1;
                  r_tx_data   <= w_grant_data;
                  r_last      <= w_grant_last;
                  r_state     <= ISSUE;
               end else begin
                  r_state <= NEXT;
               end
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
            ISSUE:     r_state <= WAIT_BUSY;
            WAIT_BUSY: if (spi_busy) r_state <= WAIT_DONE;
            WAIT_DONE: if (spi_rx_valid) begin
               r_rsp_valid <= w_grant_1h;
               r_rsp_data  <= spi_rx_data;
               r_cnt       <= '0;
               r_state     <= r_last ? HOLD : NEXT;
            end
            // Locked to the granted client; other requests wait for HOLD to finish.
            NEXT: if (w_grant_valid && !spi_busy) begin
               r_req_ready <= w_grant_1h;
               r_spi_req   <= 1'b1;
               r_tx_data   <= w_grant_data;
               r_last      <= w_grant_last;
               r_cnt       <= '0;
               r_state     <= ISSUE;
            end else if (r_cnt == CNT_W'(GAP_TIMEOUT - 1)) begin
               r_timeout <= 1'b1;
               r_cnt     <= '0;
               r_state   <= HOLD;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
            HOLD: if (r_cnt == CNT_W'(CS_HOLD - 1)) begin
               r_cs_n     <= '1;
               r_ptr      <= r_grant;
               r_arb_busy <= 1'b0;
               r_state    <= IDLE;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign req_ready   = r_req_ready;
   assign rsp_valid   = r_rsp_valid;
   assign rsp_data    = r_rsp_data;
   assign cs_n        = r_cs_n;
   assign spi_req     = r_spi_req;
   assign spi_tx_data = r_tx_data;
   assign grant_idx   = r_grant;
   assign arb_busy    = r_arb_busy;
   assign timeout_err = r_timeout;

endmodule
